// File: rtl/cmd_framer_pkg.sv
// Shared command letters, output encodings and framer state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cmd_framer_pkg;

    // ASCII command letters accepted while idle
    localparam logic [7:0] CMD_AUTO   = 8'h61; // 'a'
    localparam logic [7:0] CMD_RND    = 8'h72; // 'r'
    localparam logic [7:0] CMD_STORED = 8'h73; // 's'
    localparam logic [7:0] CMD_USER   = 8'h69; // 'i'
    localparam logic [7:0] CMD_LOAD   = 8'h70; // 'p'
    localparam logic [7:0] CMD_WRITE  = 8'h77; // 'w'
    localparam logic [7:0] CMD_UPDATE = 8'h75; // 'u'

    typedef enum logic [1:0] {
        MODE_AUTO   = 2'd0,
        MODE_RND    = 2'd1,
        MODE_STORED = 2'd2,
        MODE_USER   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CMD     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CSUM = 2'd2,
        ST_ADDR = 2'd3
    } state_e;

endpackage

// File: rtl/cmd_framer_frame_timeout.sv
// Counts slow ticks since the last clear; pulses expire on the TICKS-th one.
// Latency: expire_o is combinational in the cycle of the expiring tick.
// Backpressure: none; a clear in the same cycle suppresses expiry.
module frame_timeout #(
    parameter int TICKS = 4,
    parameter int W     = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic tick_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;

    // A clear (accepted byte) outranks a coincident expiring tick
    assign expire_o = en_i && tick_i && !clr_i && (cnt_q == W'(TICKS - 1));

    // Tick counter: restarts on clear or on expiry, advances on enabled ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i || expire_o) begin
            cnt_q <= '0;
        end else if (en_i && tick_i) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/cmd_framer.sv
// Parses received bytes into mode selects, user intensities and pattern-RAM writes.
// Latency: effects of a byte accepted in cycle N appear on the outputs in cycle N+1.
// Backpressure: none; every rx_valid byte is consumed, frames abort on tick timeout.
module cmd_framer
    import cmd_framer_pkg::*;
#(
    parameter int DATA_BYTES    = 9,
    parameter int TIMEOUT_TICKS = 4,
    parameter int TO_W          = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic                    tick,
    output logic [1:0]              mode,
    output logic [DATA_BYTES*8-1:0] user_int,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [DATA_BYTES*8-1:0] wr_data,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam int DW    = DATA_BYTES * 8;
    localparam int CNT_W = $clog2(DATA_BYTES + 1);

    state_e           state_q;
    mode_e            mode_q;
    err_e             err_code_q;
    logic [DW-1:0]    user_int_q;
    logic [DW-1:0]    shadow_q;
    logic [DW-1:0]    staging_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       acc_q;
    logic [7:0]       wr_addr_q;
    logic             wr_en_q;
    logic             err_q;
    logic             to_clr;
    logic             to_en;
    logic             to_expire;

    // Counter runs only inside a frame and restarts on every accepted byte
    assign to_clr = (state_q == ST_IDLE) || rx_valid;
    assign to_en  = (state_q != ST_IDLE);

    frame_timeout #(
        .TICKS (TIMEOUT_TICKS),
        .W     (TO_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .tick_i   (tick),
        .expire_o (to_expire)
    );

    // Framer FSM with registered outputs; an accepted byte outranks a timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_AUTO;
            err_code_q <= ERR_NONE;
            user_int_q <= '0;
            shadow_q   <= '0;
            staging_q  <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            wr_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
            if (rx_valid) begin
                unique case (state_q)
                    ST_IDLE: begin
                        case (rx_byte)
                            CMD_AUTO:   mode_q <= MODE_AUTO;
                            CMD_RND:    mode_q <= MODE_RND;
                            CMD_STORED: mode_q <= MODE_STORED;
                            CMD_USER:   mode_q <= MODE_USER;
                            CMD_UPDATE: user_int_q <= shadow_q;
                            CMD_LOAD: begin
                                cnt_q   <= '0;
                                acc_q   <= '0;
                                state_q <= ST_LOAD;
                            end
                            CMD_WRITE:  state_q <= ST_ADDR;
                            default: begin
                                err_q      <= 1'b1;
                                err_code_q <= ERR_CMD;
                            end
                        endcase
                    end
                    ST_LOAD: begin
                        staging_q <= {staging_q[DW-9:0], rx_byte};
                        acc_q     <= acc_q ^ rx_byte;
                        cnt_q     <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
                            state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_byte == acc_q) begin
                            shadow_q <= staging_q;
                        end else begin
                            err_q      <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                        state_q <= ST_IDLE;
                    end
                    ST_ADDR: begin
                        wr_addr_q <= rx_byte;
                        wr_en_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                endcase
            end else if (to_expire) begin
                state_q    <= ST_IDLE;
                staging_q  <= '0;
                err_q      <= 1'b1;
                err_code_q <= ERR_TIMEOUT;
            end
        end
    end

    assign mode     = mode_q;
    assign user_int = user_int_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = shadow_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_cmd_framer.sv
// Randomized and directed checking of cmd_framer against a byte-list reference model.
// Latency: outputs compared 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_cmd_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        tick;
    logic [1:0]  mode;
    logic [71:0] user_int;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [71:0] wr_data;
    logic        err;
    logic [1:0]  err_code;

    int n_tests = 0;
    int n_fail  = 0;

    cmd_framer #(
        .DATA_BYTES    (9),
        .TIMEOUT_TICKS (4),
        .TO_W          (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .tick     (tick),
        .mode     (mode),
        .user_int (user_int),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Reference model: frame contents kept as a plain byte list
    typedef enum int {P_IDLE, P_DATA, P_CHECK, P_ADDR} phase_t;
    phase_t      m_phase;
    logic [7:0]  m_bytes[$];
    int          m_ticks;
    logic [1:0]  m_mode;
    logic [71:0] m_user;
    logic [71:0] m_shadow;
    logic        m_wr_en;
    logic [7:0]  m_wr_addr;
    logic        m_err;
    logic [1:0]  m_code;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [71:0] frame_value();
        logic [71:0] v = '0;
        for (int i = 0; i < 9; i++) v[71-8*i -: 8] = m_bytes[i];
        return v;
    endfunction

    task automatic model(input logic v, input logic [7:0] b, input logic t, input logic r);
        logic [7:0] x;
        m_wr_en = 1'b0;
        m_err   = 1'b0;
        if (!r) begin
            m_phase = P_IDLE; m_bytes.delete(); m_ticks = 0;
            m_mode = 0; m_user = '0; m_shadow = '0;
            m_wr_addr = 0; m_code = 0;
        end else if (v) begin
            m_ticks = 0;
            case (m_phase)
                P_IDLE: begin
                    if      (b == "a") m_mode = 0;
                    else if (b == "r") m_mode = 1;
                    else if (b == "s") m_mode = 2;
                    else if (b == "i") m_mode = 3;
                    else if (b == "u") m_user = m_shadow;
                    else if (b == "p") begin m_bytes.delete(); m_phase = P_DATA; end
                    else if (b == "w") m_phase = P_ADDR;
                    else begin m_err = 1'b1; m_code = 1; end
                end
                P_DATA: begin
                    m_bytes.push_back(b);
                    if (m_bytes.size() == 9) m_phase = P_CHECK;
                end
                P_CHECK: begin
                    x = 8'h00;
                    foreach (m_bytes[i]) x = x ^ m_bytes[i];
                    if (x == b) m_shadow = frame_value();
                    else begin m_err = 1'b1; m_code = 2; end
                    m_phase = P_IDLE;
                end
                default: begin
                    m_wr_en = 1'b1; m_wr_addr = b; m_phase = P_IDLE;
                end
            endcase
        end else if (t && m_phase != P_IDLE) begin
            m_ticks++;
            if (m_ticks == 4) begin
                m_phase = P_IDLE; m_ticks = 0; m_bytes.delete();
                m_err = 1'b1; m_code = 3;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic t, input logic r);
        @(negedge clk);
        rx_valid = v; rx_byte = b; tick = t; rst_n = r;
        model(v, b, t, r);
        @(posedge clk);
        #1;
        check("mode", 72'(mode), 72'(m_mode));
        check("user_int", user_int, m_user);
        check("wr_en", 72'(wr_en), 72'(m_wr_en));
        check("wr_addr", 72'(wr_addr), 72'(m_wr_addr));
        check("wr_data", wr_data, m_shadow);
        check("err", 72'(err), 72'(m_err));
        check("err_code", 72'(err_code), 72'(m_code));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b1);
    endtask

    task automatic idle_cycle(input logic t);
        step(1'b0, 8'h00, t, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] start, input logic [7:0] csum);
        send("p");
        for (int i = 0; i < 9; i++) send(start + 8'(i));
        send(csum);
    endtask

    logic [7:0] cmds[7] = '{"a", "r", "s", "i", "p", "w", "u"};

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; tick = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("reset_mode", 72'(mode), 72'd0);
        check("reset_wr_data", wr_data, 72'd0);

        // Mode commands
        send("r"); check("mode_r", 72'(mode), 72'd1);
        send("s"); check("mode_s", 72'(mode), 72'd2);
        send("i"); check("mode_i", 72'(mode), 72'd3);
        send("a"); check("mode_a", 72'(mode), 72'd0);

        // Good frame then update
        send_frame(8'h01, 8'h01);
        send("u");
        check("user_good", user_int, 72'h010203040506070809);

        // Bad checksum keeps shadow
        send_frame(8'h11, 8'h00);
        check("csum_code", 72'(err_code), 72'd2);
        send("u");
        check("user_kept", user_int, 72'h010203040506070809);

        // Pattern write
        send("w");
        send(8'h3C);
        check("wr_pulse", 72'(wr_en), 72'd1);
        check("wr_addr_3c", 72'(wr_addr), 72'h3C);
        check("wr_data_sh", wr_data, 72'h010203040506070809);
        send("r");
        check("wr_single", 72'(wr_en), 72'd0);
        check("mode_after_w", 72'(mode), 72'd1);

        // Timeout after 3 data bytes
        send("p"); send(8'hAA); send(8'hBB); send(8'hCC);
        for (int i = 0; i < 4; i++) idle_cycle(1'b1);
        check("to_code", 72'(err_code), 72'd3);
        check("to_err", 72'(err), 72'd1);
        send("x");
        check("unk_code", 72'(err_code), 72'd1);

        // Byte coincident with expiring tick wins
        send("p"); send(8'h21); send(8'h22);
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        step(1'b1, 8'h23, 1'b1, 1'b1);
        check("race_no_err", 72'(err), 72'd0);
        for (int i = 4; i <= 9; i++) send(8'h20 + 8'(i));
        send(8'h21 ^ 8'h22 ^ 8'h23 ^ 8'h24 ^ 8'h25 ^ 8'h26 ^ 8'h27 ^ 8'h28 ^ 8'h29);
        send("u");
        check("race_user", user_int, 72'h212223242526272829);

        // Reset mid-frame clears shadow
        send("p"); send(8'h55); send(8'h66);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        send("u");
        check("rst_user", user_int, 72'd0);
        check("rst_mode", 72'(mode), 72'd0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 9) < 6) b = cmds[$urandom_range(0, 6)];
            else b = 8'($urandom);
            step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 299) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
